// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over req/ack, fixed LATENCY wait cycles.
// Optional DMEM_POST_EN macro enables posted stores through a one-entry write buffer.
module dmem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        state
);
  // Handshake: the requester raises req with we/addr/wdata stable and holds them until
  // ack; ack is a one-cycle pulse, and req still high during ack is the same request.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2, S_HOLD = 2'd3} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t            fsm;
  logic [3:0]        count;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              can_accept;
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

`ifdef DMEM_POST_EN
  logic              wb_valid;
  logic [3:0]        wb_cnt;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // A second store must wait for the buffer to drain.
  assign can_accept = !(we && wb_valid);
`else
  assign can_accept = 1'b1;
`endif

  assign state = fsm;

  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
`ifdef DMEM_POST_EN
    if (wb_valid && wb_addr == a) return wb_data;
`endif
    return mem[a];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= S_IDLE;
      count     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
`ifdef DMEM_POST_EN
      wb_valid  <= 1'b0;
      wb_cnt    <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef DMEM_POST_EN
      if (wb_valid) begin
        if (wb_cnt == 4'd0) wb_valid <= 1'b0;
        else wb_cnt <= wb_cnt - 4'd1;
      end
`endif
      case (fsm)
        S_IDLE: begin
          if (req && can_accept) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            busy      <= 1'b1;
`ifdef DMEM_POST_EN
            if (we) begin
              wb_valid <= 1'b1;
              wb_cnt   <= LAT;
              wb_addr  <= addr;
              wb_data  <= wdata;
              fsm      <= S_RESP;
              ack      <= 1'b1;
            end else if (wb_valid && wb_addr != addr) begin
              fsm <= S_HOLD;
            end else
`endif
            if (LAT == 4'd0) begin
              fsm <= S_RESP;
              ack <= 1'b1;
              if (!we) rdata <= read_word(addr);
            end else begin
              fsm   <= S_WAIT;
              count <= LAT;
            end
          end
        end
        S_WAIT: begin
          if (count == 4'd1) begin
            fsm   <= S_RESP;
            ack   <= 1'b1;
            count <= '0;
            if (!cap_we) rdata <= read_word(cap_addr);
          end else begin
            count <= count - 4'd1;
          end
        end
        S_RESP: begin
          fsm  <= S_IDLE;
          busy <= 1'b0;
        end
`ifdef DMEM_POST_EN
        S_HOLD: begin
          // Latency restarts once the buffer has committed.
          if (!wb_valid) begin
            if (LAT == 4'd0) begin
              fsm   <= S_RESP;
              ack   <= 1'b1;
              rdata <= read_word(cap_addr);
            end else begin
              fsm   <= S_WAIT;
              count <= LAT;
            end
          end
        end
`endif
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // Memory is not reset; a write is suppressed whenever reset is high.
  always_ff @(posedge clk) begin
`ifdef DMEM_POST_EN
    if (!reset && wb_valid && wb_cnt == 4'd0) mem[wb_addr] <= wb_data;
`else
    if (!reset && fsm == S_RESP && cap_we) mem[cap_addr] <= cap_wdata;
`endif
  end

endmodule
